// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-aware arbiter sharing one FIFO write port
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int HOLD_MAX   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
  input  logic [NUM_REQ-1:0]            i_last,
  output logic [NUM_REQ-1:0]            o_gnt,
  input  logic                          i_full,
  output logic                          o_wr_en,
  output logic [DATA_WIDTH-1:0]         o_wr_data,
  output logic [$clog2(NUM_REQ)-1:0]    o_wr_src,
  output logic                          o_busy,
  output logic                          o_trunc
);
  localparam int SW = $clog2(NUM_REQ);
  localparam int CW = $clog2(HOLD_MAX + 1);
  typedef enum logic {IDLE, BURST} state_t;
  state_t          state_q, state_d;
  logic [SW-1:0]   owner_q, owner_d, rr_q, rr_d, win, sel;
  logic [CW-1:0]   beat_q, beat_d, beat_nx;
  logic [SW:0]     idx;
  logic            trunc_q, trunc_d, found, sel_v, acc, hit, done;
  // Rotating priority search starting at rr_q; lowest offset wins, so scan offsets high to low
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = {1'b0, rr_q} + (SW+1)'(i);
      if (idx >= (SW+1)'(NUM_REQ)) idx = idx - (SW+1)'(NUM_REQ);
      if (i_req[idx[SW-1:0]]) begin
        win   = idx[SW-1:0];
        found = 1'b1;
      end
    end
  end
  // Port mux and next-state: in BURST only the owner is eligible; rst blanks all grants
  always_comb begin
    sel       = (state_q == BURST) ? owner_q : win;
    sel_v     = (state_q == BURST) ? i_req[sel] : found;
    acc       = sel_v && !i_full && !rst;
    beat_nx   = beat_q + CW'(1);
    hit       = (state_q == IDLE) ? (HOLD_MAX == 1) : (beat_nx == CW'(HOLD_MAX));
    done      = acc && (i_last[sel] || hit);
    o_gnt     = acc ? (NUM_REQ'(1) << sel) : '0;
    o_wr_en   = acc;
    o_wr_data = acc ? i_data[sel*DATA_WIDTH +: DATA_WIDTH] : '0;
    o_wr_src  = acc ? sel : '0;
    o_busy    = !rst && (state_q == BURST);
    state_d   = acc ? (done ? IDLE : BURST) : state_q;
    owner_d   = acc ? sel : owner_q;
    rr_d      = done ? ((sel == SW'(NUM_REQ - 1)) ? '0 : sel + SW'(1)) : rr_q;
    beat_d    = acc ? ((state_q == BURST) ? beat_nx : CW'(1)) : beat_q;
    trunc_d   = done && (state_q == BURST) && !i_last[sel];
  end
  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
      trunc_q <= trunc_d;
    end
  end
  assign o_trunc = trunc_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: table-driven checks of grant, burst lock, truncation, backpressure and reset
module tb_fifo_wr_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int tests = 0, fails = 0;

  logic       a_rst, a_full, a_wen, a_busy, a_trunc;
  logic [3:0] a_req, a_last, a_gnt;
  logic [31:0] a_data;
  logic [7:0] a_wdata;
  logic [1:0] a_src;
  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .HOLD_MAX(4)) dut_a (
    .clk(clk), .rst(a_rst), .i_req(a_req), .i_data(a_data), .i_last(a_last),
    .o_gnt(a_gnt), .i_full(a_full), .o_wr_en(a_wen), .o_wr_data(a_wdata),
    .o_wr_src(a_src), .o_busy(a_busy), .o_trunc(a_trunc));

  logic       b_rst, b_full, b_wen, b_busy, b_trunc;
  logic [2:0] b_req, b_last, b_gnt;
  logic [23:0] b_data;
  logic [7:0] b_wdata;
  logic [1:0] b_src;
  fifo_wr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .HOLD_MAX(8)) dut_b (
    .clk(clk), .rst(b_rst), .i_req(b_req), .i_data(b_data), .i_last(b_last),
    .o_gnt(b_gnt), .i_full(b_full), .o_wr_en(b_wen), .o_wr_data(b_wdata),
    .o_wr_src(b_src), .o_busy(b_busy), .o_trunc(b_trunc));

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic       full;
    logic [3:0] gnt;
    logic       busy;
    logic       trunc;
  } vec_t;
  vec_t v[26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [1:0] esrc;
    logic [1:0] rr_exp[5];
    rr_exp = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    // reset, burst lock, RR after burst
    v[0]  = '{1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
    v[1]  = '{1'b0, 4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0};
    v[2]  = '{1'b0, 4'b0110, 4'b0000, 1'b0, 4'b0010, 1'b0, 1'b0};
    v[3]  = '{1'b0, 4'b0110, 4'b0000, 1'b0, 4'b0010, 1'b1, 1'b0};
    v[4]  = '{1'b0, 4'b0110, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0};
    v[5]  = '{1'b0, 4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b0, 1'b0};
    // truncation after 4 beats of req0, req3 waiting
    v[6]  = '{1'b0, 4'b1001, 4'b1000, 1'b0, 4'b1000, 1'b0, 1'b0};
    v[7]  = '{1'b0, 4'b1001, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0};
    v[8]  = '{1'b0, 4'b1001, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0};
    v[9]  = '{1'b0, 4'b1001, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0};
    v[10] = '{1'b0, 4'b1001, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0};
    v[11] = '{1'b0, 4'b1001, 4'b1000, 1'b0, 4'b1000, 1'b0, 1'b1};
    v[12] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
    // backpressure mid-burst with owner 2, then last on the HOLD_MAX beat
    v[13] = '{1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b0};
    v[14] = '{1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b0};
    v[15] = '{1'b0, 4'b0101, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0};
    v[16] = '{1'b0, 4'b0101, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0};
    v[17] = '{1'b0, 4'b0101, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b0};
    v[18] = '{1'b0, 4'b0101, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0};
    v[19] = '{1'b0, 4'b0101, 4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0};
    // reset mid-burst
    v[20] = '{1'b0, 4'b0101, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b0};
    v[21] = '{1'b0, 4'b0101, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b0};
    v[22] = '{1'b1, 4'b0101, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
    v[23] = '{1'b0, 4'b0101, 4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0};
    // full in IDLE blocks everything, then rotation from rr=1
    v[24] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0};
    v[25] = '{1'b0, 4'b1100, 4'b1100, 1'b0, 4'b0100, 1'b0, 1'b0};

    a_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    b_data = {8'hB2, 8'hB1, 8'hB0};
    a_rst = 1'b1; a_req = 4'b1111; a_last = '0; a_full = 1'b0;
    b_rst = 1'b1; b_req = 3'b111; b_last = '0; b_full = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      a_rst = v[i].rst; a_req = v[i].req; a_last = v[i].last; a_full = v[i].full;
      #1;
      esrc = 2'd0;
      for (int k = 0; k < 4; k++) if (v[i].gnt[k]) esrc = 2'(k);
      check($sformatf("row%0d gnt", i), 32'(a_gnt), 32'(v[i].gnt));
      check($sformatf("row%0d wr_en", i), 32'(a_wen), 32'(|v[i].gnt));
      check($sformatf("row%0d wr_src", i), 32'(a_src), 32'(esrc));
      check($sformatf("row%0d wr_data", i), 32'(a_wdata), (|v[i].gnt) ? 32'hA0 + 32'(esrc) : 32'h0);
      check($sformatf("row%0d busy", i), 32'(a_busy), 32'(v[i].busy));
      check($sformatf("row%0d trunc", i), 32'(a_trunc), 32'(v[i].trunc));
    end

    // three requesters: held in reset, then per-beat rotation 0,1,2,0,1 with wrap at 2
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check($sformatf("b reset%0d gnt", i), 32'(b_gnt), 32'h0);
      check($sformatf("b reset%0d wr_en", i), 32'(b_wen), 32'h0);
    end
    @(negedge clk);
    b_rst = 1'b0; b_last = 3'b111;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("b rr%0d src", i), 32'(b_src), 32'(rr_exp[i]));
      check($sformatf("b rr%0d gnt", i), 32'(b_gnt), 32'(3'b001 << rr_exp[i]));
      check($sformatf("b rr%0d data", i), 32'(b_wdata), 32'hB0 + 32'(rr_exp[i]));
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
